token_neuron_array: RTL and testbench

Parametrised, multi-neuron generalisation of the single TickTockToken processor core. It holds NUM_NEURONS token counters with per-neuron thresholds and on-durations. Neurons accept good/bad tokens over a valid/ready stream and are evaluated by a sequential scan on each global tick. Rising and falling output edges are serialised into an event FIFO that feeds the network router.

---
 rtl/tt_token_pkg.sv | 26 ++
 rtl/token_event_fifo.sv | 54 +++++
 rtl/token_neuron_array.sv | 170 +++++++++++++++++
 tb/tb_token_neuron_array.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_token_pkg.sv
// Shared types and helpers for the token neuron array and the event router.
package tt_token_pkg;

    // Scan controller states
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fsm_e;

    // Configuration register selector
    typedef enum logic [1:0] {
        CFG_THRESH_ON  = 2'd0,
        CFG_THRESH_OFF = 2'd1,
        CFG_DURATION   = 2'd2,
        CFG_ENABLE     = 2'd3
    } cfg_sel_e;

    // Width-independent +/-1 step clamped to [lo, hi]; callers pass their own bounds.
    function automatic int sat_step(input int value, input logic up, input int lo, input int hi);
        if (up) begin
            return (value >= hi) ? hi : value + 1;
        end
        return (value <= lo) ? lo : value - 1;
    endfunction

endpackage

// File: rtl/token_event_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always presented on out_data.
module token_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             push;
    logic             pop;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign out_valid = (fill != '0);
    assign in_ready  = (fill != (PTR_W+1)'(DEPTH)) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage write; contents need no reset since fill gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/token_neuron_array.sv
// Array of token-counting neurons evaluated by a sequential scan on each global tick.
// Rise/fall edges are queued in an event FIFO feeding the network router.
module token_neuron_array
    import tt_token_pkg::*;
#(
    parameter int  NUM_NEURONS = 8,
    parameter int  COUNT_W     = 8,
    parameter int  DUR_W       = 4,
    parameter int  FIFO_DEPTH  = 4,
    localparam int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic [ID_W-1:0]    tok_id,
    input  logic               tok_good,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [ID_W-1:0]    cfg_addr,
    input  logic [1:0]         cfg_sel,
    input  logic [COUNT_W-1:0] cfg_data,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [ID_W-1:0]    ev_id,
    output logic               ev_rise,
    output logic [NUM_NEURONS-1:0] on_vec,
    output logic               tick_overrun
);

    localparam int             CNT_MAX  = (1 << (COUNT_W - 1)) - 1;
    localparam int             CNT_MIN  = -(1 << (COUNT_W - 1));
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            rise;
    } event_t;

    fsm_e                      state;
    logic [ID_W-1:0]           scan_idx;
    logic                      tick_pending;
    logic                      overrun;

    logic signed [COUNT_W-1:0] count      [NUM_NEURONS];
    logic signed [COUNT_W-1:0] thresh_on  [NUM_NEURONS];
    logic signed [COUNT_W-1:0] thresh_off [NUM_NEURONS];
    logic [DUR_W-1:0]          duration   [NUM_NEURONS];
    logic [DUR_W-1:0]          timer      [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]    on_state;
    logic [NUM_NEURONS-1:0]    enable;

    logic signed [COUNT_W-1:0] cur_count;
    logic [DUR_W-1:0]          cur_timer;
    logic [DUR_W-1:0]          timer_dec;
    logic                      want_rise;
    logic                      want_fall;
    logic                      ev_need;
    logic                      scan_stall;
    logic                      fifo_in_ready;
    event_t                    ev_in;
    event_t                    ev_out;

    assign tok_ready    = (state == IDLE);
    assign cfg_ready    = (state == IDLE);
    assign on_vec       = on_state;
    assign tick_overrun = overrun;
    assign ev_id        = ev_out.id;
    assign ev_rise      = ev_out.rise;

    // Evaluate the neuron under the scan pointer; the fall test uses the already-decremented timer
    always_comb begin
        cur_count  = count[scan_idx];
        cur_timer  = timer[scan_idx];
        timer_dec  = (cur_timer != '0) ? cur_timer - DUR_W'(1) : cur_timer;
        want_rise  = (state == SCAN) && enable[scan_idx] && !on_state[scan_idx]
                     && (cur_count >= thresh_on[scan_idx]);
        want_fall  = (state == SCAN) && enable[scan_idx] && on_state[scan_idx]
                     && ((timer_dec == '0) || (cur_count <= thresh_off[scan_idx]));
        ev_need    = want_rise || want_fall;
        scan_stall = ev_need && !fifo_in_ready;
        ev_in.id   = scan_idx;
        ev_in.rise = want_rise;
    end

    // Scan controller plus per-neuron state: tokens and config land in IDLE, evaluation in SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            scan_idx     <= '0;
            tick_pending <= 1'b0;
            overrun      <= 1'b0;
            on_state     <= '0;
            enable       <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                count[i]      <= '0;
                thresh_on[i]  <= COUNT_W'(1);
                thresh_off[i] <= '0;
                duration[i]   <= DUR_W'(1);
                timer[i]      <= '0;
            end
        end else begin
            if (tick && tick_pending) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tok_valid && enable[tok_id]) begin
                        count[tok_id] <= COUNT_W'(sat_step(int'(count[tok_id]), tok_good,
                                                           CNT_MIN, CNT_MAX));
                    end
                    // Config is applied after the token so a disable always wins
                    if (cfg_we) begin
                        case (cfg_sel_e'(cfg_sel))
                            CFG_THRESH_ON:  thresh_on[cfg_addr]  <= cfg_data;
                            CFG_THRESH_OFF: thresh_off[cfg_addr] <= cfg_data;
                            CFG_DURATION:   duration[cfg_addr]   <= cfg_data[DUR_W-1:0];
                            CFG_ENABLE: begin
                                enable[cfg_addr] <= cfg_data[0];
                                if (!cfg_data[0]) begin
                                    count[cfg_addr]    <= '0;
                                    on_state[cfg_addr] <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (tick || tick_pending) begin
                        state        <= SCAN;
                        scan_idx     <= '0;
                        tick_pending <= 1'b0;
                    end
                end
                SCAN: begin
                    if (tick) tick_pending <= 1'b1;
                    if (!scan_stall) begin
                        if (want_rise) begin
                            on_state[scan_idx] <= 1'b1;
                            timer[scan_idx]    <= duration[scan_idx];
                            count[scan_idx]    <= '0;
                        end else if (enable[scan_idx] && on_state[scan_idx]) begin
                            timer[scan_idx] <= timer_dec;
                            if (want_fall) on_state[scan_idx] <= 1'b0;
                        end
                        if (scan_idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            scan_idx <= scan_idx + ID_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    token_event_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ev_need),
        .in_ready  (fifo_in_ready),
        .in_data   (ev_in),
        .out_valid (ev_valid),
        .out_ready (ev_ready),
        .out_data  (ev_out)
    );

endmodule

// File: tb/tb_token_neuron_array.sv
// Self-checking bench for token_neuron_array against a whole-tick behavioural model.
module tb_token_neuron_array;

    localparam int N    = 8;
    localparam int CW   = 8;
    localparam int DW   = 4;
    localparam int IW   = 3;
    localparam int CMAX = 127;
    localparam int CMIN = -128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          tok_valid = 1'b0;
    logic          tok_good = 1'b0;
    logic [IW-1:0] tok_id = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [1:0]    cfg_sel = '0;
    logic [CW-1:0] cfg_data = '0;
    logic          ev_ready = 1'b1;
    logic          tok_ready, cfg_ready, ev_valid, ev_rise, tick_overrun;
    logic [IW-1:0] ev_id;
    logic [N-1:0]  on_vec;

    int checks = 0;
    int failures = 0;

    bit ready_level = 1'b1;
    bit rand_ready = 1'b0;

    int m_cnt [N];
    int m_thon [N];
    int m_thoff [N];
    int m_dur [N];
    int m_tmr [N];
    bit m_on [N];
    bit m_en [N];
    int exp_q [$];
    int act_q [$];

    token_neuron_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_id       (tok_id),
        .tok_good     (tok_good),
        .cfg_we       (cfg_we),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_id        (ev_id),
        .ev_rise      (ev_rise),
        .on_vec       (on_vec),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    // Consumer side: fixed level or random back-pressure
    always @(posedge clk) begin
        #2;
        ev_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Record every event handshake (encoded id*2+rise)
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) act_q.push_back(int'(ev_id) * 2 + int'(ev_rise));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_thon[i] = 1; m_thoff[i] = 0; m_dur[i] = 1;
            m_tmr[i] = 0; m_on[i] = 1'b0; m_en[i] = 1'b0;
        end
        exp_q.delete();
        act_q.delete();
    endtask

    // One global tick: every enabled neuron judged in index order
    task automatic model_scan();
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                if (!m_on[i] && m_cnt[i] >= m_thon[i]) begin
                    m_on[i] = 1'b1; m_tmr[i] = m_dur[i]; m_cnt[i] = 0;
                    exp_q.push_back(i * 2 + 1);
                end else if (m_on[i]) begin
                    if (m_tmr[i] > 0) m_tmr[i]--;
                    if (m_tmr[i] == 0 || m_cnt[i] <= m_thoff[i]) begin
                        m_on[i] = 1'b0;
                        exp_q.push_back(i * 2);
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] model_on();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_on[i];
        return v;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; tick = 1'b0; tok_valid = 1'b0; cfg_we = 1'b0;
        ready_level = 1'b1; rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_token(input int id, input bit good);
        int n = 0;
        tok_valid = 1'b1; tok_id = IW'(id); tok_good = good;
        @(negedge clk);
        while (!tok_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL tok_handshake tok_ready=%0b required=1", tok_ready);
        end else if (m_en[id]) begin
            if (good) m_cnt[id] = (m_cnt[id] < CMAX) ? m_cnt[id] + 1 : CMAX;
            else      m_cnt[id] = (m_cnt[id] > CMIN) ? m_cnt[id] - 1 : CMIN;
        end
    endtask

    task automatic do_cfg(input int addr, input int sel, input int data);
        int n = 0;
        cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_sel = 2'(sel); cfg_data = CW'(data);
        @(negedge clk);
        while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL cfg_handshake cfg_ready=%0b required=1", cfg_ready);
        end else begin
            case (sel)
                0: m_thon[addr] = data;
                1: m_thoff[addr] = data;
                2: m_dur[addr] = data & ((1 << DW) - 1);
                default: begin
                    m_en[addr] = ((data & 1) != 0);
                    if (!m_en[addr]) begin m_cnt[addr] = 0; m_on[addr] = 1'b0; end
                end
            endcase
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_scan();
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!tok_ready && n < 400) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL scan_finish tok_ready=%0b required=1", tok_ready);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (ev_valid && n < 400) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL fifo_drain ev_valid=%0b required=0", ev_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({tok_ready, cfg_ready, ev_valid, on_vec, tick_overrun} !== {1'b1, 1'b1, 1'b0, {N{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b cfg=%0b ev=%0b on=%h ovr=%0b required 1 1 0 00 0",
                     tok_ready, cfg_ready, ev_valid, on_vec, tick_overrun);
        end
        apply_reset();
        // Defaults leave every neuron disabled: tokens and a tick yield nothing
        do_token(0, 1'b1);
        do_tick();
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (act_q.size() !== 0 || on_vec !== '0) begin
            failures++;
            $display("FAIL reset_defaults events=%0d on=%h required 0 00", act_q.size(), on_vec);
        end
        // Mid-scan reset with a stalled scan and a sticky overrun
        for (int i = 0; i < N; i++) do_cfg(i, 3, 1);
        for (int i = 0; i < N; i++) do_token(i, 1'b1);
        ready_level = 1'b0;
        do_tick();
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (tick_overrun !== 1'b1 || ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup ovr=%0b ev=%0b required 1 1", tick_overrun, ev_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tok_ready, cfg_ready, ev_valid, on_vec, tick_overrun} !== {1'b1, 1'b1, 1'b0, {N{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_midscan got rdy=%0b cfg=%0b ev=%0b on=%h ovr=%0b required 1 1 0 00 0",
                     tok_ready, cfg_ready, ev_valid, on_vec, tick_overrun);
        end
        apply_reset();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (act_q.size() !== 0 || ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_event events=%0d ev=%0b required 0 0", act_q.size(), ev_valid);
        end
    endtask

    task automatic test_basic_fire();
        apply_reset();
        do_cfg(3, 0, 2);
        do_cfg(3, 1, -1);
        do_cfg(3, 2, 2);
        do_cfg(3, 3, 1);
        do_token(3, 1'b1);
        do_token(3, 1'b1);
        do_tick();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 1 || act_q[0] !== 7 || exp_q.size() !== 1 || on_vec[3] !== 1'b1) begin
            failures++;
            $display("FAIL basic_rise events=%0d first=%0d on=%h required 1 event {3,1}=7 on[3]=1",
                     act_q.size(), (act_q.size() > 0) ? act_q[0] : -1, on_vec);
        end
        do_tick();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== exp_q.size() || on_vec !== model_on()) begin
            failures++;
            $display("FAIL basic_hold events=%0d on=%h required %0d %h",
                     act_q.size(), on_vec, exp_q.size(), model_on());
        end
        do_tick();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 2 || act_q[1] !== 6 || on_vec !== '0) begin
            failures++;
            $display("FAIL basic_fall events=%0d on=%h required 2 events ending {3,0}=6 on=00",
                     act_q.size(), on_vec);
        end
        foreach (exp_q[k]) begin
            checks++;
            if (k >= act_q.size() || act_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL basic_event[%0d] got=%0d required=%0d", k,
                         (k < act_q.size()) ? act_q[k] : -1, exp_q[k]);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        do_cfg(0, 0, 127);
        do_cfg(0, 2, 5);
        do_cfg(0, 3, 1);
        for (int i = 0; i < 200; i++) do_token(0, 1'b1);
        do_tick();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 1 || act_q[0] !== 1 || on_vec[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_rise events=%0d on=%h required 1 event {0,1} on[0]=1", act_q.size(), on_vec);
        end
        do_cfg(0, 1, -2);
        for (int i = 0; i < 3; i++) do_token(0, 1'b0);
        do_tick();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 2 || act_q[1] !== 0 || on_vec[0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_early_fall events=%0d on=%h required 2 events ending {0,0} on[0]=0",
                     act_q.size(), on_vec);
        end
        checks++;
        if (exp_q.size() !== 2 || exp_q[1] !== 0) begin
            failures++;
            $display("FAIL sat_model_events events=%0d required 2", exp_q.size());
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        for (int i = 0; i < N; i++) do_cfg(i, 3, 1);
        for (int i = 0; i < N; i++) do_token(i, 1'b1);
        ready_level = 1'b0;
        do_tick();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (tok_ready !== 1'b0 || on_vec !== 8'h0F || ev_valid !== 1'b1 || act_q.size() !== 0) begin
            failures++;
            $display("FAIL bp_stall rdy=%0b on=%h ev=%0b events=%0d required 0 0f 1 0",
                     tok_ready, on_vec, ev_valid, act_q.size());
        end
        ready_level = 1'b1;
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== N || on_vec !== model_on()) begin
            failures++;
            $display("FAIL bp_drain events=%0d on=%h required %0d %h", act_q.size(), on_vec, N, model_on());
        end
        foreach (exp_q[k]) begin
            checks++;
            if (k >= act_q.size() || act_q[k] !== exp_q[k] || exp_q[k] !== k * 2 + 1) begin
                failures++;
                $display("FAIL bp_event[%0d] got=%0d required=%0d", k,
                         (k < act_q.size()) ? act_q[k] : -1, k * 2 + 1);
            end
        end
    endtask

    task automatic test_tick_collision();
        apply_reset();
        do_cfg(1, 1, -1);
        do_cfg(1, 3, 1);
        do_token(1, 1'b1);
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        checks++;
        if (tick_overrun !== 1'b0) begin
            failures++;
            $display("FAIL collide_pending ovr=%0b required 0", tick_overrun);
        end
        @(posedge clk); #1;
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        model_scan();
        model_scan();
        checks++;
        if (tick_overrun !== 1'b1) begin
            failures++;
            $display("FAIL collide_overrun ovr=%0b required 1", tick_overrun);
        end
        repeat (30) @(posedge clk);
        #1;
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 2 || exp_q.size() !== 2 || act_q[0] !== 3 || act_q[1] !== 2) begin
            failures++;
            $display("FAIL collide_second_scan events=%0d required 2 ({1,1} then {1,0})", act_q.size());
        end
        do_tick();
        wait_idle();
        checks++;
        if (tick_overrun !== 1'b1) begin
            failures++;
            $display("FAIL collide_sticky ovr=%0b required 1", tick_overrun);
        end
    endtask

    task automatic test_token_tick_same();
        apply_reset();
        do_cfg(2, 0, 2);
        do_cfg(2, 3, 1);
        do_token(2, 1'b1);
        tok_valid = 1'b1; tok_id = IW'(2); tok_good = 1'b1; tick = 1'b1;
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_ready tok_ready=%0b required 1", tok_ready);
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0; tick = 1'b0;
        m_cnt[2] = m_cnt[2] + 1;
        model_scan();
        wait_idle();
        wait_drain();
        checks++;
        if (act_q.size() !== 1 || act_q[0] !== 5 || exp_q.size() !== 1 || on_vec !== model_on()) begin
            failures++;
            $display("FAIL same_cycle_rise events=%0d on=%h required 1 event {2,1} on=%h",
                     act_q.size(), on_vec, model_on());
        end
    endtask

    task automatic test_random();
        apply_reset();
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                int a = int'($urandom_range(0, N - 1));
                int s = int'($urandom_range(0, 3));
                int d;
                case (s)
                    0: d = int'($urandom_range(0, 6)) - 2;
                    1: d = int'($urandom_range(0, 5)) - 4;
                    2: d = int'($urandom_range(0, 3));
                    default: d = ($urandom_range(0, 3) != 0) ? 1 : 0;
                endcase
                do_cfg(a, s, d);
            end
            for (int t = 0; t < int'($urandom_range(0, 6)); t++) begin
                do_token(int'($urandom_range(0, N - 1)), ($urandom_range(0, 9) < 7));
            end
            do_tick();
            wait_idle();
            wait_drain();
            checks++;
            if (act_q.size() !== exp_q.size() || on_vec !== model_on()) begin
                failures++;
                $display("FAIL rand_iter%0d events=%0d on=%h required %0d %h",
                         it, act_q.size(), on_vec, exp_q.size(), model_on());
            end else begin
                foreach (exp_q[k]) begin
                    checks++;
                    if (act_q[k] !== exp_q[k]) begin
                        failures++;
                        $display("FAIL rand_iter%0d_event[%0d] got=%0d required=%0d", it, k, act_q[k], exp_q[k]);
                    end
                end
            end
            exp_q.delete();
            act_q.delete();
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_saturation();
        test_back_pressure();
        test_tick_collision();
        test_token_tick_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
